// File: rtl/bsg_arb_rr_one_hot_pkg.sv
// Shared definitions for the round-robin one-hot arbiter: state encoding and
// the safe clog2 helper used to size the grant tag.
package bsg_arb_rr_one_hot_pkg;

  // The state register doubles as the grant-valid output.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // clog2 that never returns 0, so a single requester still gets a 1-bit tag.
  function automatic int safe_clog2(input int n);
    int r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bsg_arb_rr_one_hot_if.sv
// Request/grant handshake bundle between requesters, the arbiter and the grant consumer.
interface bsg_arb_rr_one_hot_if
  import bsg_arb_rr_one_hot_pkg::*;
#(parameter int width_p = 64);

  localparam int lg_width_lp = safe_clog2(width_p);

  logic [width_p-1:0]     reqs_i;
  logic [width_p-1:0]     grants_o;
  logic [lg_width_lp-1:0] tag_o;
  logic                   v_o;
  logic                   yumi_i;

  modport master (output reqs_i, yumi_i, input grants_o, tag_o, v_o);
  modport slave  (input reqs_i, yumi_i, output grants_o, tag_o, v_o);

endinterface

// File: rtl/bsg_arb_rr_one_hot_encode.sv
// One-hot to binary encoder; v reports whether any bit of the input is set.
module bsg_encode_one_hot #(
  parameter int width_p     = 64,
  parameter int lg_width_lp = 6
) (
  input  logic [width_p-1:0]     one_hot,
  output logic [lg_width_lp-1:0] addr,
  output logic                   v
);

  // With a true one-hot input the OR of the set positions is exactly its index.
  always_comb begin
    addr = '0;
    for (int i = 0; i < width_p; i++) begin
      if (one_hot[i]) addr = addr | lg_width_lp'(i);
    end
  end

  assign v = |one_hot;

endmodule

// File: rtl/bsg_arb_rr_one_hot.sv
// Registered round-robin arbiter issuing one sticky one-hot grant at a time,
// with back-to-back grants when the consumer accepts every cycle.
module bsg_arb_rr_one_hot
  import bsg_arb_rr_one_hot_pkg::*;
#(parameter int width_p = 64)
(
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  bsg_arb_rr_one_hot_if.slave  arb
);

  localparam int lg_width_lp = safe_clog2(width_p);

  arb_state_e             state_r, state_n;
  logic [width_p-1:0]     grants_r, grants_n;
  logic [lg_width_lp-1:0] tag_r, tag_n, last_r, last_n;
  logic [lg_width_lp-1:0] ptr, next_tag;
  logic [width_p-1:0]     live_reqs, rot, pick, next_grant;
  logic                   accept, winner;

  // On accept the current holder is masked so a still-high line cannot win twice in a row.
  assign accept    = (state_r == BUSY) && arb.yumi_i;
  assign ptr       = (state_r == BUSY) ? tag_r : last_r;
  assign live_reqs = arb.reqs_i & ~(accept ? grants_r : '0);

  always_comb begin
    rot = '0;
    for (int j = 0; j < width_p; j++) begin
      rot[j] = live_reqs[(j + int'(ptr) + 1) % width_p];
    end
  end

  assign pick = rot & (~rot + width_p'(1));

  always_comb begin
    next_grant = '0;
    for (int j = 0; j < width_p; j++) begin
      next_grant[(j + int'(ptr) + 1) % width_p] = pick[j];
    end
  end

  bsg_encode_one_hot #(
    .width_p     (width_p),
    .lg_width_lp (lg_width_lp)
  ) encode (
    .one_hot (next_grant),
    .addr    (next_tag),
    .v       (winner)
  );

  // A missing winner leaves next_grant/next_tag at zero, which is exactly the idle output.
  always_comb begin
    state_n  = state_r;
    grants_n = grants_r;
    tag_n    = tag_r;
    last_n   = last_r;
    case (state_r)
      IDLE: begin
        if (winner) begin
          grants_n = next_grant;
          tag_n    = next_tag;
          state_n  = BUSY;
        end
      end
      BUSY: begin
        if (arb.yumi_i) begin
          last_n   = tag_r;
          grants_n = next_grant;
          tag_n    = next_tag;
          state_n  = winner ? BUSY : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r  <= IDLE;
      grants_r <= '0;
      tag_r    <= '0;
      last_r   <= lg_width_lp'(width_p - 1);
    end else begin
      state_r  <= state_n;
      grants_r <= grants_n;
      tag_r    <= tag_n;
      last_r   <= last_n;
    end
  end

  assign arb.grants_o = grants_r;
  assign arb.tag_o    = tag_r;
  assign arb.v_o      = (state_r == BUSY);

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    arb.yumi_i |-> (state_r == BUSY));
  a_grant_one_hot: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (state_r == BUSY) |-> ($onehot(grants_r) && ((grants_r >> tag_r) == width_p'(1))));
  a_idle_no_grant: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (state_r == IDLE) |-> (grants_r == '0));

endmodule

// File: tb/tb_bsg_arb_rr_one_hot.sv
// Scoreboard bench for bsg_arb_rr_one_hot at widths 8, 1, 5 and 64.
module tb_bsg_arb_rr_one_hot;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          sel = 0;
  int          cur_w = 8;
  logic [63:0] drv_reqs = '0;
  logic        drv_yumi = 1'b0;
  logic        obs_v;
  logic [63:0] obs_g;
  int          obs_t;
  int          total = 0;
  int          bad = 0;
  int          expq[$];
  int          hist[64];
  int          cyc;

  always #5 clk = ~clk;

  bsg_arb_rr_one_hot_if #(.width_p(8))  if8  ();
  bsg_arb_rr_one_hot_if #(.width_p(1))  if1  ();
  bsg_arb_rr_one_hot_if #(.width_p(5))  if5  ();
  bsg_arb_rr_one_hot_if #(.width_p(64)) if64 ();

  bsg_arb_rr_one_hot #(.width_p(8))  dut8  (.clk_i(clk), .reset_n_i(rst_n), .arb(if8.slave));
  bsg_arb_rr_one_hot #(.width_p(1))  dut1  (.clk_i(clk), .reset_n_i(rst_n), .arb(if1.slave));
  bsg_arb_rr_one_hot #(.width_p(5))  dut5  (.clk_i(clk), .reset_n_i(rst_n), .arb(if5.slave));
  bsg_arb_rr_one_hot #(.width_p(64)) dut64 (.clk_i(clk), .reset_n_i(rst_n), .arb(if64.slave));

  assign if8.reqs_i  = (sel == 0) ? drv_reqs[7:0] : 8'h0;
  assign if8.yumi_i  = (sel == 0) && drv_yumi;
  assign if1.reqs_i  = (sel == 1) ? drv_reqs[0:0] : 1'b0;
  assign if1.yumi_i  = (sel == 1) && drv_yumi;
  assign if5.reqs_i  = (sel == 2) ? drv_reqs[4:0] : 5'h0;
  assign if5.yumi_i  = (sel == 2) && drv_yumi;
  assign if64.reqs_i = (sel == 3) ? drv_reqs : 64'h0;
  assign if64.yumi_i = (sel == 3) && drv_yumi;

  always_comb begin
    obs_v = 1'b0;
    obs_g = '0;
    obs_t = 0;
    case (sel)
      0: begin obs_v = if8.v_o;  obs_g = 64'(if8.grants_o);  obs_t = int'(if8.tag_o);  end
      1: begin obs_v = if1.v_o;  obs_g = 64'(if1.grants_o);  obs_t = int'(if1.tag_o);  end
      2: begin obs_v = if5.v_o;  obs_g = 64'(if5.grants_o);  obs_t = int'(if5.tag_o);  end
      default: begin obs_v = if64.v_o; obs_g = if64.grants_o; obs_t = int'(if64.tag_o); end
    endcase
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int idxOf(input logic [63:0] v);
    for (int i = 0; i < 64; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference scan: first requester after ptr, wrapping; the holder itself may be excluded.
  function automatic int nextIdx(input logic [63:0] r, input int w, input int ptr, input bit excl);
    for (int k = 1; k <= w; k++) begin
      int i = (ptr + k) % w;
      if (r[i] && !(excl && i == ptr)) return i;
    end
    return -1;
  endfunction

  task automatic checkInvariants();
    if (obs_v) begin
      checkOutput("inv_onehot", 64'($onehot(obs_g)), 64'd1);
      checkOutput("inv_tag_idx", 64'(obs_t), 64'(idxOf(obs_g)));
    end else begin
      checkOutput("inv_idle_zero", obs_g, 64'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    drv_yumi = 1'b0;
    drv_reqs = '0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_v", 64'(obs_v), 64'd0);
    checkOutput("rst_grants", obs_g, 64'd0);
    checkOutput("rst_tag", 64'(obs_t), 64'd0);
    rst_n = 1'b1;
  endtask

  // Drives a constant request pattern and queues the grant order it must produce.
  task automatic applyStimulus(input logic [63:0] reqs, input int n);
    int ptr = cur_w - 1;
    bit excl = 1'b0;
    drv_reqs = reqs;
    for (int k = 0; k < n; k++) begin
      int i = nextIdx(reqs, cur_w, ptr, excl);
      expq.push_back(i);
      ptr  = i;
      excl = 1'b1;
    end
  endtask

  task automatic runAccepts(input int n, input int pct, output int cycles);
    int got = 0;
    cycles = 0;
    drv_yumi = 1'b0;
    while (got < n && cycles < 4000) begin
      step();
      cycles++;
      checkInvariants();
      drv_yumi = obs_v && ($urandom_range(99) < pct);
      if (drv_yumi) begin
        if (expq.size() == 0) begin
          checkOutput("queue_underflow", 64'd1, 64'd0);
        end else begin
          int e = expq.pop_front();
          checkOutput("grant_tag", 64'(obs_t), 64'(e));
          checkOutput("grant_vec", obs_g, 64'd1 << e);
        end
        hist[obs_t]++;
        got++;
      end
    end
    if (got < n) checkOutput("accept_timeout", 64'(got), 64'(n));
  endtask

  initial begin
    // Test 1: no requests keeps everything idle.
    sel = 0; cur_w = 8;
    doReset();
    repeat (10) begin
      step();
      checkOutput("t1_v", 64'(obs_v), 64'd0);
      checkOutput("t1_grants", obs_g, 64'd0);
      checkOutput("t1_tag", 64'(obs_t), 64'd0);
    end

    // Test 2: sparse pattern, accept every cycle, no bubbles.
    doReset();
    applyStimulus(64'h94, 30);
    runAccepts(30, 100, cyc);
    checkOutput("t2_cycles", 64'(cyc), 64'd30);

    // Test 3: sticky grant without yumi, even after the request drops.
    doReset();
    drv_reqs = 64'h1;
    for (int k = 0; k < 7; k++) begin
      if (k == 5) drv_reqs = '0;
      step();
      checkOutput("t3_v", 64'(obs_v), 64'd1);
      checkOutput("t3_grants", obs_g, 64'd1);
      checkOutput("t3_tag", 64'(obs_t), 64'd0);
    end
    drv_yumi = 1'b1;
    step();
    drv_yumi = 1'b0;
    checkOutput("t3_drop_v", 64'(obs_v), 64'd0);
    checkOutput("t3_drop_grants", obs_g, 64'd0);

    // Test 4: all requests high, random accepts, fairness.
    doReset();
    foreach (hist[i]) hist[i] = 0;
    applyStimulus(64'hFF, 800);
    runAccepts(800, 50, cyc);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("t4_count%0d", i), 64'(hist[i]), 64'd100);

    // Test 5: asynchronous reset while tag 5 is presented.
    doReset();
    applyStimulus(64'hFF, 5);
    runAccepts(5, 100, cyc);
    step();
    drv_yumi = 1'b0;
    checkOutput("t5_pre_v", 64'(obs_v), 64'd1);
    checkOutput("t5_pre_tag", 64'(obs_t), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_async_v", 64'(obs_v), 64'd0);
    checkOutput("t5_async_grants", obs_g, 64'd0);
    checkOutput("t5_async_tag", 64'(obs_t), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    checkOutput("t5_post_v", 64'(obs_v), 64'd1);
    checkOutput("t5_post_tag", 64'(obs_t), 64'd0);

    // Test 6a: single requester alternates grant and idle.
    sel = 1; cur_w = 1;
    doReset();
    drv_reqs = 64'h1;
    for (int k = 0; k < 6; k++) expq.push_back((k % 2 == 0) ? 1 : 0);
    repeat (6) begin
      int ev;
      step();
      checkInvariants();
      ev = expq.pop_front();
      checkOutput("t6_w1_v", 64'(obs_v), 64'(ev));
      checkOutput("t6_w1_tag", 64'(obs_t), 64'd0);
      drv_yumi = obs_v;
    end

    // Test 6b/6c: same pattern at widths 5 and 64.
    sel = 2; cur_w = 5;
    doReset();
    applyStimulus(64'h94 & 64'h1F, 12);
    runAccepts(12, 100, cyc);
    checkOutput("t6_w5_cycles", 64'(cyc), 64'd12);

    sel = 3; cur_w = 64;
    doReset();
    applyStimulus(64'h94, 12);
    runAccepts(12, 100, cyc);
    checkOutput("t6_w64_cycles", 64'(cyc), 64'd12);

    drv_yumi = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
